// File: rtl/axi_lite_accel_regs_if.sv
// rtl/axi_lite_accel_regs_if.sv - AXI4-Lite bus bundle for the accelerator register bank
interface axi_lite_accel_regs_if #(
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int C_S_AXI_DATA_WIDTH = 32
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr;
  logic                            awvalid;
  logic                            awready;
  logic [C_S_AXI_DATA_WIDTH-1:0]   wdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                            wvalid;
  logic                            wready;
  logic [1:0]                      bresp;
  logic                            bvalid;
  logic                            bready;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   araddr;
  logic                            arvalid;
  logic                            arready;
  logic [C_S_AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                      rresp;
  logic                            rvalid;
  logic                            rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_accel_regs.sv
// rtl/axi_lite_accel_regs.sv - AXI4-Lite register bank with start/done handshake for a compute accelerator
// Optional irq output and CTRL.IRQ_EN bit are enabled by defining AXI_ACCEL_IRQ_EN.
module axi_lite_accel_regs #(
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int OPERAND_WIDTH      = 8,
  parameter int NUM_OPERANDS       = 2,
  parameter int RESULT_WIDTH       = 9
) (
  input  logic                                  S_AXI_ACLK,
  input  logic                                  S_AXI_ARESETN,
  axi_lite_accel_regs_if.slave                  s_axi,
  output logic [NUM_OPERANDS*OPERAND_WIDTH-1:0] op_data,
  output logic                                  op_start,
  input  logic                                  res_valid,
  input  logic [RESULT_WIDTH-1:0]               res_data
`ifdef AXI_ACCEL_IRQ_EN
  ,
  output logic                                  irq
`endif
);
  localparam int         WORD_W      = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_BUSY     = 1'b1;

  logic [0:0]                    state;
  logic                          done;
  logic                          irq_en;
  logic [RESULT_WIDTH-1:0]       result;
  logic [OPERAND_WIDTH-1:0]      operand [NUM_OPERANDS];

  logic                          aw_held, w_held;
  logic [WORD_W-1:0]             aw_word;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data;
  logic [3:0]                    w_strb;
  logic                          awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]                    bresp_q, rresp_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

  logic aw_hs, w_hs, ar_hs, commit;
  logic aw_held_n, w_held_n, bvalid_n, rvalid_n;
  logic wr_ctrl, wr_status, wr_result;
  logic [NUM_OPERANDS-1:0]       wr_op_sel;
  logic [1:0]                    wr_resp;
  logic [31:0]                   wmask;
  logic [WORD_W-1:0]             rd_word;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_data;
  logic [1:0]                    rd_resp;
  logic                          unused_bits;

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;

  assign aw_hs  = s_axi.awvalid && awready_q;
  assign w_hs   = s_axi.wvalid && wready_q;
  assign ar_hs  = s_axi.arvalid && arready_q;
  assign commit = aw_held && w_held;

  assign aw_held_n = commit ? 1'b0 : (aw_held | aw_hs);
  assign w_held_n  = commit ? 1'b0 : (w_held | w_hs);
  assign bvalid_n  = commit | (bvalid_q & ~s_axi.bready);
  assign rvalid_n  = ar_hs | (rvalid_q & ~s_axi.rready);

  assign wmask = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};

  assign wr_ctrl   = (aw_word == WORD_W'(0));
  assign wr_status = (aw_word == WORD_W'(1));
  assign wr_result = (aw_word == WORD_W'(2));

  always_comb begin
    wr_op_sel = '0;
    for (int i = 0; i < NUM_OPERANDS; i++) wr_op_sel[i] = (aw_word == WORD_W'(4 + i));
  end

  // Operands are frozen while the accelerator computes, so such writes are refused.
  assign wr_resp = (!(wr_ctrl | wr_status | wr_result | (|wr_op_sel)) ||
                    ((|wr_op_sel) && state == ST_BUSY)) ? RESP_SLVERR : RESP_OKAY;

  always_comb begin
    rd_word = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
    rd_data = '0;
    rd_resp = RESP_OKAY;
    if (rd_word == WORD_W'(0)) begin
      rd_data[1] = irq_en;
    end else if (rd_word == WORD_W'(1)) begin
      rd_data[1] = done;
      rd_data[0] = (state == ST_BUSY);
    end else if (rd_word == WORD_W'(2)) begin
      rd_data = C_S_AXI_DATA_WIDTH'(result);
    end else begin
      rd_resp = RESP_SLVERR;
      for (int i = 0; i < NUM_OPERANDS; i++) begin
        if (rd_word == WORD_W'(4 + i)) begin
          rd_data = C_S_AXI_DATA_WIDTH'(operand[i]);
          rd_resp = RESP_OKAY;
        end
      end
    end
  end

  always_comb begin
    op_data = '0;
    for (int i = 0; i < NUM_OPERANDS; i++) op_data[i*OPERAND_WIDTH +: OPERAND_WIDTH] = operand[i];
  end

  assign unused_bits = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0], wmask, w_data};

`ifndef AXI_ACCEL_IRQ_EN
  assign irq_en = 1'b0;
`endif

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state     <= ST_IDLE;
      done      <= 1'b0;
      result    <= '0;
      op_start  <= 1'b0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_word   <= '0;
      w_data    <= '0;
      w_strb    <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      for (int i = 0; i < NUM_OPERANDS; i++) operand[i] <= '0;
`ifdef AXI_ACCEL_IRQ_EN
      irq_en    <= 1'b0;
      irq       <= 1'b0;
`endif
    end else begin
      aw_held   <= aw_held_n;
      w_held    <= w_held_n;
      bvalid_q  <= bvalid_n;
      rvalid_q  <= rvalid_n;
      awready_q <= !aw_held_n && !bvalid_n;
      wready_q  <= !w_held_n && !bvalid_n;
      arready_q <= !arready_q && !rvalid_n;
      op_start  <= 1'b0;

      if (aw_hs) aw_word <= s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
      if (w_hs) begin
        w_data <= s_axi.wdata;
        w_strb <= s_axi.wstrb;
      end
      if (commit) bresp_q <= wr_resp;
      if (ar_hs) begin
        rdata_q <= rd_data;
        rresp_q <= rd_resp;
      end

      for (int i = 0; i < NUM_OPERANDS; i++) begin
        if (commit && wr_op_sel[i] && state == ST_IDLE)
          operand[i] <= (operand[i] & ~wmask[OPERAND_WIDTH-1:0]) |
                        (w_data[OPERAND_WIDTH-1:0] & wmask[OPERAND_WIDTH-1:0]);
      end

      // W1C is applied first so a result strobe on the same edge sets DONE back.
      if (commit && wr_status && w_strb[0] && w_data[1]) done <= 1'b0;

      if (state == ST_BUSY && res_valid) begin
        result <= res_data;
        done   <= 1'b1;
        state  <= ST_IDLE;
      end else if (state == ST_IDLE && commit && wr_ctrl && w_strb[0] && w_data[0]) begin
        state    <= ST_BUSY;
        op_start <= 1'b1;
        done     <= 1'b0;
      end

`ifdef AXI_ACCEL_IRQ_EN
      if (commit && wr_ctrl && w_strb[0]) irq_en <= w_data[1];
      irq <= done && irq_en;
`endif
    end
  end
endmodule
